macarray_gen2: RTL and testbench
================================

# macarray_gen2

Parametrised, second-generation matrix-multiply engine computing OUT(T×M) = IN(T×N) · W(N×M) for run-time M, N, T in 1..DIM. It streams input rows and transposed-weight rows from two synchronous read-only SRAMs and writes packed signed results to a read/write output SRAM. Unused output entries are zero-filled. New in this generation: width, dimension and lane parameters, an accumulate mode (OUT += IN·W via read-modify-write), edge-triggered start, and BUSY/DONE/ERR status.

## Interface
- DW, 4: signed element width of input and weight.
- DIM, 8: maximum M/N/T; also the number of elements per input/weight word; must be ≤ 15.
- LANES, 4: output elements per output word.
- OW, 16: signed output element width (two's complement, wraps).
- G, derived = ceil(DIM/LANES): column groups.
- AIW, derived = clog2(DIM): ADDR_I/ADDR_W width. AOW, derived = clog2(DIM*G): ADDR_O width.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RSTN  in  1  asynchronous active-low reset.
- START  in  1  run request; rising edge sampled in IDLE.
- MNT  in  12  M=[11:8], N=[7:4], T=[3:0]; latched at start.
- ACC  in  1  1 = accumulate into existing output; latched at start.
- EN_I / EN_W  out  1  input / weight SRAM read enable.
- ADDR_I / ADDR_W  out  AIW  row address.
- RDATA_I / RDATA_W  in  DIM*DW  row data, valid the cycle after enable.
- EN_O  out  1  output SRAM enable. RW_O  out  1  1 = write, 0 = read.
- ADDR_O  out  AOW  output address. WDATA_O  out  LANES*OW  write data.
- RDATA_O  in  LANES*OW  read data, valid the cycle after read.
- BUSY  out  1  run in progress. DONE  out  1  one-cycle completion pulse. ERR  out  1  last start had invalid MNT; held until next start.

## Operation
- Packing: element k (column k+1) of RDATA_I/RDATA_W at bits [(DIM-1-k)*DW +: DW]; lane l at WDATA_O/RDATA_O bits [(LANES-1-l)*OW +: OW] (element 1 in MSBs).
- Start: start_q registers START (reset 0); run begins when state=IDLE, START=1, start_q=0. START during a run is ignored; holding START high yields exactly one run.
- Invalid MNT (any field 0 or >DIM): no SRAM enables, ERR=1, DONE pulses the next cycle, back to IDLE.
- Sweep: g = 0..G-1 outer, t = 0..DIM-1 inner; every tile writes ADDR_O = g*DIM + t, so all DIM*G words are written.
- Per tile states: RDI → RDW(l = 0..LANES-1) → LAST → WR.
  - RDI: EN_I=1, ADDR_I=t only if t<T.
  - RDW l: EN_W=1, ADDR_W=g*LANES+l only if that m<M; input row captured at end of RDW0; weight of lane l-1 captured at end of RDW l.
  - LAST: capture lane LANES-1; if ACC and t<T: EN_O=1, RW_O=0, ADDR_O of this tile.
  - WR: EN_O=1, RW_O=1, WDATA_O = lane sums (+ RDATA_O lane if ACC).
- Lane value = Σ_{k<N} in[k]·w[k], signed, sign-extended/truncated to OW bits; elements k≥N masked to 0.
- Lanes with t≥T or m≥M are forced to 0 even in ACC mode.
- After last WR: DONE state (DONE=1, BUSY=0) for one cycle, then IDLE.

## Timing
- Reset values: all enables, RW_O, BUSY, DONE, ERR = 0; addresses and WDATA_O = 0; state IDLE.
- Tile = LANES+3 cycles. The first RDI is the cycle after the start edge; DONE occurs DIM*G*(LANES+3)+1 cycles after the start edge (113 with defaults).
- BUSY = 1 from the first RDI through the last WR.
- Addresses and enables registered; an SRAM never sees its enable without a valid address.
- Reset mid-run: immediate return to IDLE with reset outputs; partially written output is not cleaned.

## Test plan
- MNT=12'h888, ACC=0, all elements 1 → all 16 words 0x0008000800080008; DONE at cycle 113; ERR=0.
- MNT=12'h666, ACC=0, all 1 → addr0–5 0x0006000600060006; addr8–13 0x0006000600000000; addr6,7,14,15 zero.
- MNT=12'h888, all elements 4'h8 (−8) → every lane 0x0200; input −1, weight 7 → 0xFFC8.
- Run 12'h888 all-1 with ACC=0, drop START, then raise it with ACC=1 → all lanes 0x0010; START held high after the second run causes no third run.
- MNT=12'h090 → ERR=1, DONE pulse next cycle, EN_I/EN_W/EN_O never asserted.
- RSTN low at cycle 40 of a run → all outputs at reset values within the reset; a new START runs a full correct pass.

Source files
------------

// File: rtl/macarray_gen2.sv
// macarray_gen2: tiled matrix-multiply engine, OUT(TxM) = IN(TxN) * W(NxM).
// Each tile reads one input row and LANES transposed-weight rows, forms LANES
// dot products and writes one packed output word, optionally accumulating
// into the word already stored at that address.
module macarray_gen2 #(
  parameter int DW    = 4,
  parameter int DIM   = 8,
  parameter int LANES = 4,
  parameter int OW    = 16,
  parameter int G     = (DIM + LANES - 1) / LANES,
  parameter int AIW   = $clog2(DIM),
  parameter int AOW   = $clog2(DIM * G)
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  START,
  input  logic [11:0]           MNT,
  input  logic                  ACC,
  output logic                  EN_I,
  output logic                  EN_W,
  output logic [AIW-1:0]        ADDR_I,
  output logic [AIW-1:0]        ADDR_W,
  input  logic [DIM*DW-1:0]     RDATA_I,
  input  logic [DIM*DW-1:0]     RDATA_W,
  output logic                  EN_O,
  output logic                  RW_O,
  output logic [AOW-1:0]        ADDR_O,
  output logic [LANES*OW-1:0]   WDATA_O,
  input  logic [LANES*OW-1:0]   RDATA_O,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR
);

  // Dot-product accumulator width: holds up to 15 full-scale products.
  localparam int SW = 2 * DW + 4;

  localparam logic [7:0] DIM8   = 8'(DIM);
  localparam logic [7:0] LANES8 = 8'(LANES);
  localparam logic [7:0] G_LAST = 8'(G - 1);
  localparam logic [7:0] T_LAST = 8'(DIM - 1);
  localparam logic [7:0] L_LAST = 8'(LANES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RDI,
    S_RDW,
    S_LAST,
    S_WR,
    S_DONE
  } state_t;

  state_t state;

  logic       start_q;
  logic [3:0] m_q, n_q, t_q;
  logic       acc_q;
  logic [7:0] g_cnt, t_cnt, l_cnt;

  logic [DIM*DW-1:0]      in_row_p0;
  logic signed [OW-1:0]   lane_sum_p1 [LANES];
  logic signed [OW-1:0]   w_dot;

  logic       start_edge;
  logic       mnt_ok;
  logic       last_tile;
  logic [7:0] t_nxt, g_nxt;
  logic [7:0] m_first, m_next;
  logic [7:0] m_ext, t_ext;

  // Sign-extend or truncate a dot-product sum to the output element width.
  function automatic logic signed [OW-1:0] wrap_ow(input logic signed [SW-1:0] s);
    logic signed [SW+OW-1:0] wide;
    wide = s;
    return wide[OW-1:0];
  endfunction

  // Two's-complement wrapping add of two output elements.
  function automatic logic signed [OW-1:0] add_wrap(input logic signed [OW-1:0] a,
                                                     input logic signed [OW-1:0] b);
    return a + b;
  endfunction

  // Signed dot product over the first n elements of two packed rows.
  function automatic logic signed [OW-1:0] dot(input logic [DIM*DW-1:0] a,
                                                input logic [DIM*DW-1:0] b,
                                                input logic [3:0]        n);
    logic signed [SW-1:0]   s;
    logic signed [DW-1:0]   ea, eb;
    logic signed [2*DW-1:0] p;
    s = '0;
    for (int k = 0; k < DIM; k++) begin
      ea = a[(DIM-1-k)*DW +: DW];
      eb = b[(DIM-1-k)*DW +: DW];
      p  = ea * eb;
      if (k < int'(n)) s = s + SW'(p);
    end
    return wrap_ow(s);
  endfunction

  // Output column index served by lane ln of column group g.
  function automatic logic [7:0] lane_m(input logic [7:0] g, input int ln);
    return g * LANES8 + 8'(ln);
  endfunction

  assign start_edge = START & ~start_q;
  assign mnt_ok     = (MNT[11:8] != 4'd0) && ({4'd0, MNT[11:8]} <= DIM8) &&
                      (MNT[7:4]  != 4'd0) && ({4'd0, MNT[7:4]}  <= DIM8) &&
                      (MNT[3:0]  != 4'd0) && ({4'd0, MNT[3:0]}  <= DIM8);
  assign last_tile  = (g_cnt == G_LAST) && (t_cnt == T_LAST);
  assign t_nxt      = (t_cnt == T_LAST) ? 8'd0 : t_cnt + 8'd1;
  assign g_nxt      = (t_cnt == T_LAST) ? g_cnt + 8'd1 : g_cnt;
  assign m_first    = g_cnt * LANES8;
  assign m_next     = g_cnt * LANES8 + l_cnt + 8'd1;
  assign m_ext      = {4'd0, m_q};
  assign t_ext      = {4'd0, t_q};
  assign w_dot      = dot(in_row_p0, RDATA_W, n_q);

  // Previous START level, so that only a rising edge launches a run.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) start_q <= 1'b0;
    else       start_q <= START;
  end

  // Sequencer: walks groups and rows, drives registered SRAM controls and status.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state  <= S_IDLE;
      m_q    <= '0;
      n_q    <= '0;
      t_q    <= '0;
      acc_q  <= 1'b0;
      g_cnt  <= '0;
      t_cnt  <= '0;
      l_cnt  <= '0;
      EN_I   <= 1'b0;
      EN_W   <= 1'b0;
      EN_O   <= 1'b0;
      RW_O   <= 1'b0;
      ADDR_I <= '0;
      ADDR_W <= '0;
      ADDR_O <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_edge) begin
            m_q   <= MNT[11:8];
            n_q   <= MNT[7:4];
            t_q   <= MNT[3:0];
            acc_q <= ACC;
            if (mnt_ok) begin
              ERR    <= 1'b0;
              BUSY   <= 1'b1;
              g_cnt  <= '0;
              t_cnt  <= '0;
              l_cnt  <= '0;
              EN_I   <= 1'b1;
              ADDR_I <= '0;
              state  <= S_RDI;
            end else begin
              ERR   <= 1'b1;
              DONE  <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_RDI: begin
          EN_I   <= 1'b0;
          l_cnt  <= '0;
          EN_W   <= (m_first < m_ext);
          ADDR_W <= AIW'(m_first);
          state  <= S_RDW;
        end
        S_RDW: begin
          if (l_cnt == L_LAST) begin
            EN_W   <= 1'b0;
            EN_O   <= acc_q && (t_cnt < t_ext);
            RW_O   <= 1'b0;
            ADDR_O <= AOW'(g_cnt * DIM8 + t_cnt);
            state  <= S_LAST;
          end else begin
            l_cnt  <= l_cnt + 8'd1;
            EN_W   <= (m_next < m_ext);
            ADDR_W <= AIW'(m_next);
          end
        end
        S_LAST: begin
          EN_O  <= 1'b1;
          RW_O  <= 1'b1;
          state <= S_WR;
        end
        S_WR: begin
          EN_O <= 1'b0;
          RW_O <= 1'b0;
          if (last_tile) begin
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= S_DONE;
          end else begin
            g_cnt  <= g_nxt;
            t_cnt  <= t_nxt;
            EN_I   <= (t_nxt < t_ext);
            ADDR_I <= AIW'(t_nxt);
            state  <= S_RDI;
          end
        end
        S_DONE: begin
          DONE  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Capture the input row, then one lane dot product per returning weight row.
  always_ff @(posedge CLK) begin
    if (state == S_RDW && l_cnt == 8'd0) in_row_p0 <= RDATA_I;
    for (int ln = 0; ln < LANES - 1; ln++) begin
      if (state == S_RDW && l_cnt == 8'(ln + 1)) lane_sum_p1[ln] <= w_dot;
    end
    if (state == S_LAST) lane_sum_p1[LANES-1] <= w_dot;
  end

  // Write word: valid lanes carry their sum (plus stored value when accumulating).
  always_comb begin
    WDATA_O = '0;
    if (state == S_WR && t_cnt < t_ext) begin
      for (int ln = 0; ln < LANES; ln++) begin
        if (lane_m(g_cnt, ln) < m_ext) begin
          WDATA_O[(LANES-1-ln)*OW +: OW] =
            add_wrap(lane_sum_p1[ln],
                     acc_q ? $signed(RDATA_O[(LANES-1-ln)*OW +: OW]) : {OW{1'b0}});
        end
      end
    end
  end

endmodule

// File: tb/tb_macarray_gen2.sv
// Self-checking bench for macarray_gen2: SRAM models, a matrix-level reference
// model of the output memory, and a write monitor comparing every output word.
module tb_macarray_gen2;

  localparam int DW      = 4;
  localparam int DIM     = 8;
  localparam int LANES   = 4;
  localparam int OW      = 16;
  localparam int G       = (DIM + LANES - 1) / LANES;
  localparam int NW      = DIM * G;
  localparam int AIW     = $clog2(DIM);
  localparam int AOW     = $clog2(NW);
  localparam int RUN_CYC = NW * (LANES + 3) + 1;

  logic                clk;
  logic                rstn;
  logic                start;
  logic [11:0]         mnt;
  logic                acc;
  logic                en_i, en_w, en_o, rw_o;
  logic [AIW-1:0]      addr_i, addr_w;
  logic [AOW-1:0]      addr_o;
  logic [DIM*DW-1:0]   rdata_i, rdata_w;
  logic [LANES*OW-1:0] wdata_o, rdata_o;
  logic                busy, done, err;

  macarray_gen2 #(.DW(DW), .DIM(DIM), .LANES(LANES), .OW(OW)) dut (
    .CLK(clk), .RSTN(rstn), .START(start), .MNT(mnt), .ACC(acc),
    .EN_I(en_i), .EN_W(en_w), .ADDR_I(addr_i), .ADDR_W(addr_w),
    .RDATA_I(rdata_i), .RDATA_W(rdata_w),
    .EN_O(en_o), .RW_O(rw_o), .ADDR_O(addr_o), .WDATA_O(wdata_o),
    .RDATA_O(rdata_o), .BUSY(busy), .DONE(done), .ERR(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Matrices as plain integers, plus their packed SRAM images.
  int                  in_el [DIM][DIM];
  int                  w_el  [DIM][DIM];
  logic [DIM*DW-1:0]   mem_i [DIM];
  logic [DIM*DW-1:0]   mem_w [DIM];
  logic [LANES*OW-1:0] mem_o [NW];
  logic [LANES*OW-1:0] exp_mem [NW];

  int chk = 0;
  int errs = 0;
  int cur_m = 0, cur_t = 0;
  bit cur_valid = 1'b0;
  int run_id = 0;
  int seen_id = 0;
  int wr_cnt = 0;

  // Synchronous SRAMs: read data valid the cycle after enable.
  always @(posedge clk) begin
    if (en_i) rdata_i <= mem_i[addr_i];
    if (en_w) rdata_w <= mem_w[addr_w];
    if (en_o) begin
      if (rw_o) mem_o[addr_o] <= wdata_o;
      else      rdata_o <= mem_o[addr_o];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic pack_rows();
    for (int r = 0; r < DIM; r++) begin
      logic [DIM*DW-1:0] ri, rw;
      ri = '0;
      rw = '0;
      for (int k = 0; k < DIM; k++) begin
        ri[(DIM-1-k)*DW +: DW] = DW'(in_el[r][k]);
        rw[(DIM-1-k)*DW +: DW] = DW'(w_el[r][k]);
      end
      mem_i[r] = ri;
      mem_w[r] = rw;
    end
  endtask

  task automatic load_const(input int iv, input int wv);
    for (int r = 0; r < DIM; r++)
      for (int k = 0; k < DIM; k++) begin
        in_el[r][k] = iv;
        w_el[r][k]  = wv;
      end
    pack_rows();
  endtask

  task automatic load_rand();
    for (int r = 0; r < DIM; r++)
      for (int k = 0; k < DIM; k++) begin
        in_el[r][k] = int'($urandom_range(0, 15)) - 8;
        w_el[r][k]  = int'($urandom_range(0, 15)) - 8;
      end
    pack_rows();
  endtask

  // Expected output memory after a run: OUT = IN*W (+ old OUT), zero outside TxM.
  task automatic build_model(input int m, input int n, input int t, input bit a);
    for (int adr = 0; adr < NW; adr++) begin
      logic [LANES*OW-1:0] word;
      int g, row;
      g = adr / DIM;
      row = adr % DIM;
      word = '0;
      for (int ln = 0; ln < LANES; ln++) begin
        int col, s;
        logic [OW-1:0] lv;
        col = g * LANES + ln;
        s = 0;
        if (row < t && col < m) begin
          for (int k = 0; k < n; k++) s += in_el[row][k] * w_el[col][k];
          if (a) s += int'($signed(mem_o[adr][(LANES-1-ln)*OW +: OW]));
        end
        lv = OW'(s);
        word[(LANES-1-ln)*OW +: OW] = lv;
      end
      exp_mem[adr] = word;
    end
  endtask

  task automatic start_run(input logic [11:0] req, input bit a);
    int m, n, t;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    m = int'(req[11:8]);
    n = int'(req[7:4]);
    t = int'(req[3:0]);
    cur_valid = (m >= 1 && m <= DIM && n >= 1 && n <= DIM && t >= 1 && t <= DIM);
    cur_m = m;
    cur_t = t;
    if (cur_valid) build_model(m, n, t, a);
    run_id++;
    mnt = req;
    acc = a;
    start = 1'b1;
  endtask

  task automatic wait_done();
    int cyc, dcyc, busy_bad, en_bad;
    cyc = 0;
    dcyc = -1;
    busy_bad = 0;
    en_bad = 0;
    while (dcyc < 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (busy !== (cur_valid && cyc <= RUN_CYC - 1)) busy_bad++;
      if (!cur_valid && (en_i || en_w || en_o)) en_bad++;
      if (done === 1'b1) dcyc = cyc;
    end
    check("done_cycle", 64'(dcyc), cur_valid ? 64'(RUN_CYC) : 64'd1);
    check("busy_profile", 64'(busy_bad), 64'd0);
    if (!cur_valid) check("no_enables", 64'(en_bad), 64'd0);
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
    check("err_flag", 64'(err), 64'(!cur_valid));
    if (cur_valid) check("write_count", 64'(wr_cnt), 64'(NW));
  endtask

  // Compare process: every output write against the model, every read address in range.
  always @(negedge clk) begin
    if (run_id != seen_id) begin
      seen_id = run_id;
      wr_cnt = 0;
    end
    if (rstn) begin
      if (en_o && rw_o) begin
        check("wr_addr", 64'(addr_o), 64'(wr_cnt));
        check("wr_data", wdata_o, exp_mem[addr_o]);
        wr_cnt++;
      end
      if (en_i) check("en_i_row", 64'(int'(addr_i) < cur_t), 64'd1);
      if (en_w) check("en_w_col", 64'(int'(addr_w) < cur_m), 64'd1);
    end
  end

  initial begin
    int act;
    rstn = 1'b0;
    start = 1'b0;
    mnt = '0;
    acc = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctl", 64'({en_i, en_w, en_o, rw_o, busy, done, err, addr_i, addr_w, addr_o}), 64'd0);
    check("reset_wdata", wdata_o, 64'd0);
    rstn = 1'b1;

    // Full size, all ones.
    load_const(1, 1);
    start_run(12'h888, 1'b0);
    wait_done();
    check("lit_888_w0", mem_o[0], 64'h0008000800080008);
    check("lit_888_w15", mem_o[15], 64'h0008000800080008);

    // 6x6x6, all ones: zero fill outside.
    start_run(12'h666, 1'b0);
    wait_done();
    check("lit_666_w0", mem_o[0], 64'h0006000600060006);
    check("lit_666_w5", mem_o[5], 64'h0006000600060006);
    check("lit_666_w8", mem_o[8], 64'h0006000600000000);
    check("lit_666_w13", mem_o[13], 64'h0006000600000000);
    check("lit_666_w6", mem_o[6], 64'h0);
    check("lit_666_w15", mem_o[15], 64'h0);

    // Signed extremes.
    load_const(-8, -8);
    start_run(12'h888, 1'b0);
    wait_done();
    check("lit_neg8", mem_o[9], 64'h0200020002000200);
    load_const(-1, 7);
    start_run(12'h888, 1'b0);
    wait_done();
    check("lit_m1x7", mem_o[2], 64'hFFC8FFC8FFC8FFC8);

    // Accumulate, then hold START high: no further run.
    load_const(1, 1);
    start_run(12'h888, 1'b0);
    wait_done();
    start_run(12'h888, 1'b1);
    wait_done();
    check("lit_acc", mem_o[7], 64'h0010001000100010);
    act = 0;
    repeat (150) begin
      @(negedge clk);
      if (busy || en_i || en_w || en_o || done) act++;
    end
    check("no_rerun_hold", 64'(act), 64'd0);

    // Invalid dimensions.
    start_run(12'h090, 1'b0);
    wait_done();
    repeat (3) @(negedge clk);
    check("err_held", 64'(err), 64'd1);

    // Reset in the middle of a run, then a clean full pass.
    load_rand();
    start_run(12'h888, 1'b0);
    repeat (40) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("midrst_ctl", 64'({en_i, en_w, en_o, rw_o, busy, done, err, addr_i, addr_w, addr_o}), 64'd0);
    check("midrst_wdata", wdata_o, 64'd0);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_hold", 64'({en_i, en_w, en_o, rw_o, busy, done, err}), 64'd0);
    rstn = 1'b1;
    start_run(12'h888, 1'b0);
    wait_done();

    // Random shapes and data, alternating accumulate.
    for (int i = 0; i < 5; i++) begin
      logic [3:0] rm, rn, rt;
      rm = 4'($urandom_range(1, DIM));
      rn = 4'($urandom_range(1, DIM));
      rt = 4'($urandom_range(1, DIM));
      load_rand();
      start_run({rm, rn, rt}, i[0]);
      wait_done();
    end

    $display("CHECKS %0d ERRORS %0d", chk, errs);
    $finish;
  end

endmodule
